// File: rtl/decode_redirect_pkg.sv
// Shared definitions for the decode/redirect stage.
// Holds the control-flow opcodes, branch funct3 codes, the bubble
// instruction word, the RUN/FLUSH state type and immediate extractors.
package decode_redirect_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_redirect_branch_compare.sv
// Branch condition evaluator.
// Ports:
//   i_rs1_data, i_rs2_data : operands from the register file
//   i_funct3               : branch kind
//   o_taken                : condition holds (funct3 010/011 never taken)
module branch_compare
    import decode_redirect_pkg::*;
(
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [2:0]  i_funct3,
    output logic        o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = (i_rs1_data == i_rs2_data);
            F3_BNE:  o_taken = (i_rs1_data != i_rs2_data);
            F3_BLT:  o_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            F3_BGE:  o_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            F3_BLTU: o_taken = (i_rs1_data <  i_rs2_data);
            F3_BGEU: o_taken = (i_rs1_data >= i_rs2_data);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_redirect.sv
// Decode-stage register with jump/branch redirect and wrong-path squash.
//
// state | meaning
// RUN   | normal decode; loads fetch output unless stalled, may redirect
// FLUSH | squashing wrong-path fetch slots after a redirect
//
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   pc, instruction              : fetch-stage outputs
//   stall                        : hold the decode register
//   rs1_data, rs2_data           : register-file read data
//   rs1_addr, rs2_addr           : register-file read addresses
//   id_pc, id_instruction        : decode-stage registers
//   id_valid                     : decode slot holds a real instruction
//   jump_branch_condition/address: redirect request and target to fetch
module decode_redirect
    import decode_redirect_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        jump_branch_condition,
    output logic [31:0] jump_branch_address
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;

    state_t      w_state_nxt;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_instr_nxt;
    logic        w_id_valid_nxt;

    logic [6:0]  w_opcode;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_branch;
    logic        w_br_taken;
    logic        w_redirect;
    logic [31:0] w_jalr_sum;

    assign rs1_addr       = r_id_instr[19:15];
    assign rs2_addr       = r_id_instr[24:20];
    assign id_pc          = r_id_pc;
    assign id_instruction = r_id_instr;
    assign id_valid       = r_id_valid;

    assign w_opcode    = r_id_instr[6:0];
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_jalr_sum  = rs1_data + imm_i(r_id_instr);

    branch_compare u_branch_compare (
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .i_funct3   (r_id_instr[14:12]),
        .o_taken    (w_br_taken)
    );

    assign w_redirect = r_id_valid && (r_state == ST_RUN) && !stall &&
                        (w_is_jal || w_is_jalr || (w_is_branch && w_br_taken));

    always_comb begin
        jump_branch_condition = w_redirect;
        jump_branch_address   = 32'h0;
        if (w_redirect) begin
            if (w_is_jal) begin
                jump_branch_address = r_id_pc + imm_j(r_id_instr);
            end else if (w_is_jalr) begin
                jump_branch_address = w_jalr_sum & 32'hFFFF_FFFE;
            end else begin
                jump_branch_address = r_id_pc + imm_b(r_id_instr);
            end
        end
    end

    // The redirect edge itself squashes the first wrong-path slot, so FLUSH
    // holds for FLUSH_DEPTH-1 further bubbles. Once the counter has run out,
    // the FLUSH edge behaves like a RUN load; the slot it replaces is a
    // bubble, so no redirect can be missed there.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_id_pc_nxt    = r_id_pc;
        w_id_instr_nxt = r_id_instr;
        w_id_valid_nxt = r_id_valid;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_state_nxt    = ST_FLUSH;
                    w_cnt_nxt      = FLUSH_INIT;
                    w_id_pc_nxt    = pc;
                    w_id_instr_nxt = NOP_INSTR;
                    w_id_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_id_pc_nxt    = pc;
                    w_id_instr_nxt = instruction;
                    w_id_valid_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_cnt != 2'd0) begin
                    w_cnt_nxt      = r_cnt - 2'd1;
                    w_id_pc_nxt    = pc;
                    w_id_instr_nxt = NOP_INSTR;
                    w_id_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (!stall) begin
                        w_id_pc_nxt    = pc;
                        w_id_instr_nxt = instruction;
                        w_id_valid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= 2'd0;
            r_id_pc    <= 32'h0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_instr <= w_id_instr_nxt;
            r_id_valid <= w_id_valid_nxt;
        end
    end

endmodule
